// File: rtl/div_float_pkg.sv
// div_float_pkg: shared types and helpers for the sequential float divider.
//   state_t   - top-level controller states
//   clog2_f   - ceiling log2 for sizing counters
//   fp_width  - total word width {sign, exp, man}
//   fp_bias   - exponent bias for a given exponent width
package div_float_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_DONE
  } state_t;

  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned fp_width(input int unsigned exp_w,
                                           input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/div_mant_seq.sv
// div_mant_seq: radix-2 restoring mantissa divider, one quotient bit per clock.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_start        - load i_ma / i_mb and begin a division
//   i_ma, i_mb     - mantissas with hidden bit, {1, man}
//   o_busy         - division in progress
//   o_done         - high in the cycle whose clock edge produces the last bit
//   o_q            - floor(ma * 2^(MAN_W+1) / mb), MAN_W+2 bits
module div_mant_seq
  import div_float_pkg::*;
#(
  parameter int unsigned MAN_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [MAN_W:0]   i_ma,
  input  logic [MAN_W:0]   i_mb,
  output logic             o_busy,
  output logic             o_done,
  output logic [MAN_W+1:0] o_q
);

  localparam int unsigned RW    = MAN_W + 2;
  localparam int unsigned CNT_W = clog2_f(MAN_W + 3);

  logic [RW-1:0]    rem_q, rem_d;
  logic [MAN_W:0]   mb_q, mb_d;
  logic [RW-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [RW-1:0] step_rem, step_div, step_diff, step_next;
  logic          step_bit, last;

  always_comb begin
    // The first quotient bit is resolved on the start edge directly from the
    // operand inputs, so MAN_W+2 bits complete MAN_W+1 edges after start.
    step_rem  = i_start ? {1'b0, i_ma} : rem_q;
    step_div  = i_start ? {1'b0, i_mb} : {1'b0, mb_q};
    step_bit  = (step_rem >= step_div);
    step_diff = step_bit ? (step_rem - step_div) : step_rem;
    step_next = step_diff << 1;
    last      = busy_q && (cnt_q == CNT_W'(MAN_W + 1));

    rem_d  = rem_q;
    mb_d   = mb_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (i_start) begin
      rem_d  = step_next;
      mb_d   = i_mb;
      quo_d  = {{(RW-1){1'b0}}, step_bit};
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = step_next;
      quo_d  = {quo_q[RW-2:0], step_bit};
      cnt_d  = cnt_q + 1'b1;
      busy_d = !last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q  <= '0;
      mb_q   <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      mb_q   <= mb_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = last;
  assign o_q    = quo_q;

endmodule

// File: rtl/div_float_seq.sv
// div_float_seq: multi-cycle floating-point divider with valid/ready on both
// sides. Format {sign, exp, man}; exponent 0 is zero (subnormals flushed), no
// inf/NaN. Mantissa truncated; exponent saturates or flushes with flags.
//   i_Clk, i_Rst_n          - clock, asynchronous active-low reset
//   i_Valid / o_Ready       - operand handshake
//   i_Dividend, i_Divisor   - operands, W bits
//   o_Valid / i_Ready       - result handshake
//   o_Quotient              - result, W bits
//   o_DivZero / o_Overflow / o_Underflow - result status, at most one high
module div_float_seq
  import div_float_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  localparam int unsigned W    = fp_width(EXP_W, MAN_W)
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [W-1:0] i_Dividend,
  input  logic [W-1:0] i_Divisor,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [W-1:0] o_Quotient,
  output logic         o_DivZero,
  output logic         o_Overflow,
  output logic         o_Underflow
);

  localparam int unsigned BIAS = fp_bias(EXP_W);
  localparam logic [EXP_W+1:0] BIAS_X = (EXP_W + 2)'(BIAS);

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W-1:0]   ea_q, ea_d;
  logic [EXP_W-1:0]   eb_q, eb_d;
  logic [W-1:0]       quot_q, quot_d;
  logic               divz_q, divz_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;
  logic               accept;

  logic               core_start, core_busy, core_done;
  logic [MAN_W+1:0]   core_q;

  logic               norm_hi;
  logic [MAN_W-1:0]   norm_man;
  logic [EXP_W+1:0]   norm_e;
  logic               norm_ovf, norm_unf;

  assign a_sign = i_Dividend[W-1];
  assign a_exp  = i_Dividend[W-2 -: EXP_W];
  assign a_man  = i_Dividend[MAN_W-1:0];
  assign b_sign = i_Divisor[W-1];
  assign b_exp  = i_Divisor[W-2 -: EXP_W];
  assign b_man  = i_Divisor[MAN_W-1:0];
  assign accept = i_Valid && ready_q;

  div_mant_seq #(
    .MAN_W(MAN_W)
  ) u_mant (
    .i_clk   (i_Clk),
    .i_rst_n (i_Rst_n),
    .i_start (core_start),
    .i_ma    ({1'b1, a_man}),
    .i_mb    ({1'b1, b_man}),
    .o_busy  (core_busy),
    .o_done  (core_done),
    .o_q     (core_q)
  );

  always_comb begin
    // Quotient lies in [2^MAN_W, 2^(MAN_W+2)); the top bit picks the shift.
    // Exponent is evaluated modulo 2^(EXP_W+2), so bit EXP_W+1 is its sign.
    norm_hi  = core_q[MAN_W+1];
    norm_man = norm_hi ? core_q[MAN_W:1] : core_q[MAN_W-1:0];
    norm_e   = {2'b00, ea_q} - {2'b00, eb_q} + BIAS_X
             - {{(EXP_W+1){1'b0}}, ~norm_hi};
    norm_ovf = !norm_e[EXP_W+1] && norm_e[EXP_W];
    norm_unf = norm_e[EXP_W+1] || (norm_e == '0);

    state_d    = state_q;
    sign_d     = sign_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    quot_d     = quot_q;
    divz_d     = divz_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    core_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d = a_sign ^ b_sign;
          ea_d   = a_exp;
          eb_d   = b_exp;
          if (b_exp == '0) begin
            state_d = S_DONE;
            quot_d  = {a_sign ^ b_sign, {(W-1){1'b1}}};
            divz_d  = 1'b1;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
          end else if (a_exp == '0) begin
            state_d = S_DONE;
            quot_d  = '0;
            divz_d  = 1'b0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
          end else begin
            state_d    = S_DIV;
            core_start = 1'b1;
          end
        end
      end
      S_DIV: begin
        // The idle check keeps the controller from stalling if the core ever
        // finished without being observed.
        if (core_done || !core_busy) state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_DONE;
        divz_d  = 1'b0;
        ovf_d   = norm_ovf;
        unf_d   = norm_unf;
        if (norm_ovf)      quot_d = {sign_q, {(W-1){1'b1}}};
        else if (norm_unf) quot_d = '0;
        else               quot_d = {sign_q, norm_e[EXP_W-1:0], norm_man};
      end
      S_DONE: begin
        if (valid_q && i_Ready) begin
          state_d = S_IDLE;
          divz_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // o_Valid trails entry into DONE by one cycle, for both the special and
    // the normal path.
    valid_d = (state_q == S_DONE) && !(valid_q && i_Ready);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      quot_q  <= '0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      quot_q  <= quot_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_Ready     = ready_q;
  assign o_Valid     = valid_q;
  assign o_Quotient  = quot_q;
  assign o_DivZero   = divz_q;
  assign o_Overflow  = ovf_q;
  assign o_Underflow = unf_q;

endmodule

// File: tb/tb_div_float_seq.sv
// Testbench for div_float_seq: half-precision and single-precision instances,
// directed vectors plus random single-precision normals against a reference.
module tb_div_float_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        h_ivalid, h_oready, h_ovalid, h_iready;
  logic [15:0] h_a, h_b, h_q;
  logic        h_dz, h_ov, h_un;

  logic        s_ivalid, s_oready, s_ovalid, s_iready;
  logic [31:0] s_a, s_b, s_q;
  logic        s_dz, s_ov, s_un;

  int total  = 0;
  int passed = 0;

  div_float_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(h_ivalid), .o_Ready(h_oready),
    .i_Dividend(h_a), .i_Divisor(h_b), .o_Valid(h_ovalid), .i_Ready(h_iready),
    .o_Quotient(h_q), .o_DivZero(h_dz), .o_Overflow(h_ov), .o_Underflow(h_un)
  );

  div_float_seq #(.EXP_W(8), .MAN_W(23)) dut_s (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(s_ivalid), .o_Ready(s_oready),
    .i_Dividend(s_a), .i_Divisor(s_b), .o_Valid(s_ovalid), .i_Ready(s_iready),
    .o_Quotient(s_q), .o_DivZero(s_dz), .o_Overflow(s_ov), .o_Underflow(s_un)
  );

  // Single-precision truncating reference: {divzero, overflow, underflow, q}.
  function automatic logic [34:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic            sgn, hi;
    longint unsigned ma, mb, q;
    logic [22:0]     man;
    int              e;
    sgn = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {3'b100, sgn, 31'h7FFFFFFF};
    if (a[30:23] == 8'd0) return {3'b000, 32'h0};
    ma  = {40'd0, 1'b1, a[22:0]};
    mb  = {40'd0, 1'b1, b[22:0]};
    q   = (ma << 24) / mb;
    hi  = q[24];
    man = hi ? q[23:1] : q[22:0];
    e   = int'(a[30:23]) - int'(b[30:23]) + 127 - (hi ? 0 : 1);
    if (e > 255) return {3'b010, sgn, 31'h7FFFFFFF};
    if (e < 1)   return {3'b001, 32'h0};
    return {3'b000, sgn, e[7:0], man};
  endfunction

  // Issue one half-precision operation with i_Ready high; report the result,
  // flags and the number of edges from the accept edge to o_Valid.
  task automatic op_h(input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] q, output logic [2:0] f, output int lat);
    @(negedge clk);
    h_a = a; h_b = b; h_ivalid = 1'b1; h_iready = 1'b1;
    @(posedge clk); #1;
    h_ivalid = 1'b0; h_a = 16'hDEAD; h_b = 16'hBEEF;
    lat = 0;
    while (!h_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q = h_q;
    f = {h_dz, h_ov, h_un};
    @(posedge clk); #1;
  endtask

  task automatic op_s(input logic [31:0] a, input logic [31:0] b,
                      output logic [34:0] r, output int lat);
    @(negedge clk);
    s_a = a; s_b = b; s_ivalid = 1'b1; s_iready = 1'b1;
    @(posedge clk); #1;
    s_ivalid = 1'b0; s_a = 32'hDEADBEEF; s_b = 32'h12345678;
    lat = 0;
    while (!s_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = {s_dz, s_ov, s_un, s_q};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++;
    if ({h_oready, h_ovalid, h_q, h_dz, h_ov, h_un} !== {1'b1, 1'b0, 16'h0, 3'b000})
      $display("FAIL reset_h: got rdy=%b vld=%b q=%h f=%b want rdy=1 vld=0 q=0000 f=000",
               h_oready, h_ovalid, h_q, {h_dz, h_ov, h_un});
    else passed++;
    total++;
    if ({s_oready, s_ovalid, s_q, s_dz, s_ov, s_un} !== {1'b1, 1'b0, 32'h0, 3'b000})
      $display("FAIL reset_s: got rdy=%b vld=%b q=%h want rdy=1 vld=0 q=0", s_oready, s_ovalid, s_q);
    else passed++;
  endtask

  task automatic test_half_vectors();
    logic [15:0] ta [12] = '{16'h3C00, 16'h4600, 16'h3C00, 16'hC600, 16'h3C00, 16'h0000,
                             16'h0000, 16'h7800, 16'h0400, 16'h7C00, 16'h7C00, 16'h0400};
    logic [15:0] tb [12] = '{16'h3C00, 16'h4200, 16'h4200, 16'h4200, 16'h8000, 16'h4200,
                             16'h0000, 16'h0400, 16'h7800, 16'h3C00, 16'h3800, 16'h3C00};
    logic [15:0] tq [12] = '{16'h3C00, 16'h4000, 16'h3555, 16'hC000, 16'hFFFF, 16'h0000,
                             16'h7FFF, 16'h7FFF, 16'h0000, 16'h7C00, 16'h7FFF, 16'h0400};
    logic [2:0]  tf [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                             3'b100, 3'b010, 3'b001, 3'b000, 3'b010, 3'b000};
    int          tl [12] = '{13, 13, 13, 13, 1, 1, 1, 13, 13, 13, 13, 13};
    logic [15:0] q;
    logic [2:0]  f;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      op_h(ta[i], tb[i], q, f, lat);
      total++;
      if (q !== tq[i]) $display("FAIL half_q[%0d] %h/%h: got %h want %h", i, ta[i], tb[i], q, tq[i]);
      else passed++;
      total++;
      if (f !== tf[i]) $display("FAIL half_flags[%0d]: got %b want %b", i, f, tf[i]);
      else passed++;
      total++;
      if (lat != tl[i]) $display("FAIL half_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
      else passed++;
    end
  endtask

  task automatic test_underflow_boundary();
    logic [15:0] q;
    logic [2:0]  f;
    int          lat;
    op_h(16'h0400, 16'h4000, q, f, lat);
    total++;
    if ({f, q} !== {3'b001, 16'h0000}) $display("FAIL unf_e0: got f=%b q=%h want f=001 q=0000", f, q);
    else passed++;
    op_h(16'h0400, 16'h3E00, q, f, lat);
    total++;
    if ({f, q} !== {3'b001, 16'h0000}) $display("FAIL unf_adj: got f=%b q=%h want f=001 q=0000", f, q);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    h_a = 16'h3C00; h_b = 16'h4200; h_ivalid = 1'b1; h_iready = 1'b0;
    @(posedge clk); #1;
    h_ivalid = 1'b0; h_a = 16'h0; h_b = 16'h0;
    lat = 0;
    while (!h_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 13) $display("FAIL bp_latency: got %0d want 13", lat);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if ({h_ovalid, h_oready, h_q, h_dz, h_ov, h_un} !== {1'b1, 1'b0, 16'h3555, 3'b000})
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%h want vld=1 rdy=0 q=3555",
                 c, h_ovalid, h_oready, h_q);
      else passed++;
    end
    @(negedge clk);
    h_iready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({h_ovalid, h_oready} !== 2'b01) $display("FAIL bp_release: got vld/rdy=%b want 01", {h_ovalid, h_oready});
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    h_a = 16'h3C00; h_b = 16'h3C00; h_ivalid = 1'b1; h_iready = 1'b1;
    @(posedge clk); #1;
    // Second pair held valid throughout; it must be ignored until idle.
    h_a = 16'h4600; h_b = 16'h4200;
    lat = 0;
    while (!h_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if ({h_q, h_oready} !== {16'h3C00, 1'b0}) $display("FAIL b2b_first: got q=%h rdy=%b want q=3c00 rdy=0", h_q, h_oready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({h_ovalid, h_oready} !== 2'b01) $display("FAIL b2b_idle: got vld/rdy=%b want 01", {h_ovalid, h_oready});
    else passed++;
    @(posedge clk); #1;
    total++;
    if (h_oready !== 1'b0) $display("FAIL b2b_accept: got rdy=%b want 0", h_oready);
    else passed++;
    h_ivalid = 1'b0;
    lat = 0;
    while (!h_ovalid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 13 || h_q !== 16'h4000) $display("FAIL b2b_second: got lat=%0d q=%h want lat=13 q=4000", lat, h_q);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int          seen;
    logic [15:0] q;
    logic [2:0]  f;
    int          lat;
    @(negedge clk);
    h_a = 16'h4600; h_b = 16'h4200; h_ivalid = 1'b1; h_iready = 1'b1;
    @(posedge clk); #1;
    h_ivalid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({h_ovalid, h_oready, h_q, h_dz, h_ov, h_un} !== {1'b0, 1'b1, 16'h0, 3'b000})
      $display("FAIL abort_outputs: got vld=%b rdy=%b q=%h f=%b want vld=0 rdy=1 q=0000 f=000",
               h_ovalid, h_oready, h_q, {h_dz, h_ov, h_un});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (h_ovalid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen);
    else passed++;
    op_h(16'h3C00, 16'h4200, q, f, lat);
    total++;
    if ({f, q} !== {3'b000, 16'h3555} || lat != 13)
      $display("FAIL abort_recover: got f=%b q=%h lat=%0d want f=000 q=3555 lat=13", f, q, lat);
    else passed++;
  endtask

  task automatic test_single();
    logic [34:0] r, want;
    logic [31:0] a, b;
    int          lat;
    op_s(32'h3F800000, 32'h40400000, r, lat);
    total++;
    if (r !== {3'b000, 32'h3EAAAAAA}) $display("FAIL single_third: got %h want 03eaaaaaa", r);
    else passed++;
    total++;
    if (lat != 26) $display("FAIL single_latency: got %0d want 26", lat);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i < 5) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      if (a[30:23] == 8'd0) a[30:23] = 8'd1;
      if (b[30:23] == 8'd0) b[30:23] = 8'd1;
      want = ref32(a, b);
      op_s(a, b, r, lat);
      total++;
      if (r !== want) $display("FAIL single_rand[%0d] %h/%h: got %h want %h", i, a, b, r, want);
      else passed++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    h_ivalid = 1'b0; h_iready = 1'b1; h_a = '0; h_b = '0;
    s_ivalid = 1'b0; s_iready = 1'b1; s_a = '0; s_b = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_half_vectors();
    test_underflow_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_float_seq.md
# div_float_seq

Multi-cycle, parametrised floating-point divider for the pipeline's divider stage. It succeeds the combinational half-precision divider with three changes: configurable exponent and mantissa widths, a valid/ready handshake on both sides, and separate divide-by-zero, overflow and underflow flags. The mantissa quotient is computed by radix-2 restoring division, one quotient bit per clock, so the block trades latency for area.

## Interface
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width; the hidden bit is implicit.
- Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
- i_Clk  in  1  clock; everything is rising-edge.
- i_Rst_n  in  1  reset, asynchronous and active-low.
- i_Valid  in  1  operand pair valid.
- o_Ready  out  1  block can accept operands.
- i_Dividend  in  W  {sign, exp, man}.
- i_Divisor  in  W  {sign, exp, man}.
- o_Valid  out  1  result valid.
- i_Ready  in  1  downstream accepts the result.
- o_Quotient  out  W  result.
- o_DivZero  out  1  divisor magnitude was zero.
- o_Overflow  out  1  result exponent above range; result saturated.
- o_Underflow  out  1  result exponent below range; result flushed.

## Operation
- Number format:
  - exponent field 0 means zero; subnormal inputs are flushed to zero.
  - no inf/NaN encoding; the all-ones exponent is an ordinary normal value.
- Accept on i_Valid && o_Ready. Capture the operands and sign = sign_a ^ sign_b.
- States:
  - IDLE: o_Ready=1. Transitions on accept:
    - divisor zero -> DONE with {sign, all ones} and o_DivZero=1.
    - else dividend zero -> DONE with all-zero W bits.
    - else -> DIV.
  - DIV: MAN_W+2 iterations. Ma, Mb = {1,man}. Each cycle: partial remainder compared against Mb, one quotient bit produced. Result q = floor(Ma*2^(MAN_W+1)/Mb), with 2^MAN_W <= q < 2^(MAN_W+2). Iteration counter width is clog2(MAN_W+3). Then -> NORM.
  - NORM:
    - if q[MAN_W+1]=1: man = q[MAN_W:1], adj = 0.
    - else: man = q[MAN_W-1:0], adj = -1.
    - Rounding is truncation.
    - e = Ea - Eb + BIAS + adj, computed signed in EXP_W+2 bits.
    - e > 2^EXP_W-1: {sign, all ones}, o_Overflow=1.
    - e < 1: all-zero W bits, o_Underflow=1.
    - else: {sign, e[EXP_W-1:0], man}.
    - -> DONE.
  - DONE: o_Valid=1. On i_Ready -> IDLE.
- At most one flag is high per result.
- The flags are sticky only for the duration of o_Valid.

## Timing
- Reset values:
  - state IDLE, so o_Ready=1.
  - o_Valid, o_Quotient, o_DivZero, o_Overflow, o_Underflow all 0.
- Latency, with the accept edge as cycle 0:
  - normal: o_Valid high after edge MAN_W+3, which is 13 for half precision.
  - special case (zero divisor or dividend): o_Valid high after edge 1.
- o_Ready is low from the accept edge until the edge that completes the output handshake. It is 1 in the cycle after that.
- No overlap: one operation in flight.
- While o_Valid && !i_Ready, o_Quotient and the flags hold stable indefinitely.
- i_Valid while o_Ready=0 is ignored; operands are not captured.
- Operand inputs may change freely after the accept edge.
- Reset asserted mid-operation aborts it immediately. Outputs go to reset values; no o_Valid is produced for the aborted pair.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package div_float_pkg holds:
  - state encoding (IDLE, DIV, NORM, DONE).
  - the BIAS/W derivation function.
  - a clog2 function.
- Sub-module div_mant_seq holds:
  - the restoring mantissa core: start/busy/done, Ma/Mb in, q out.
- The top level holds:
  - handshake
  - special cases
  - exponent math
  - normalisation
  - saturation

## Test plan
- 0x3C00/0x3C00 -> 0x3C00. 0x4600/0x4200 -> 0x4000. 0x3C00/0x4200 -> 0x3555. All flags 0; o_Valid at cycle 13.
- 0xC600/0x4200 -> 0xC000. 0x3C00/0x8000 -> 0xFFFF, o_DivZero=1, o_Valid at cycle 1. 0x0000/0x4200 -> 0x0000.
- 0x7800/0x0400 -> 0x7FFF, o_Overflow=1. 0x0400/0x7800 -> 0x0000, o_Underflow=1.
- i_Ready held low 5 cycles after o_Valid -> outputs stable and o_Ready=0 throughout. Back-to-back i_Valid -> second pair accepted exactly one cycle after the output handshake.
- i_Rst_n pulsed low at cycle 6 of a divide -> all outputs zero, o_Ready=1, no o_Valid. The next operation gives the correct result.
- Parameter sweep EXP_W=8/MAN_W=23: 0x3F800000/0x40400000 -> 0x3EAAAAAA, o_Valid at cycle 26. Random normals checked against a truncating reference model.
